sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller for the 16-bit external SRAM behind the MEM stage. It converts one 32-bit word read or write from the pipeline into two sequenced 16-bit SRAM accesses. It holds `ready` low for the whole access; the pipeline drives the pipeline-register freeze input with `~ready`. This stalls the EX/MEM register and all earlier stages until the word transfer completes.

## Interface
- `ACCESS_CYCLES`, default 2: cycles each 16-bit half-access is held on the SRAM pins (≥1).
- `BASE_ADDR`, default 32'd1024: CPU byte address that maps to SRAM word 0.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  word read request from MEM stage (MEM_R_EN).
- `wr_en`  in  1  word write request from MEM stage (MEM_W_EN).
- `address`  in  32  CPU byte address (ALU_result).
- `writeData`  in  32  store data (Val_Rm).
- `readData`  out  32  last completed read word.
- `ready`  out  1  high = no access pending or access finishing this cycle; freeze = ~ready.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM halfword address.
- `SRAM_WE_N`  out  1  write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied 0.

## Operation
- States: IDLE, LOW, HIGH, DONE. Counter `cnt` is ceil(log2(ACCESS_CYCLES))+1 bits wide.
- IDLE, `rd_en|wr_en`=1:
  - latch the op; `wr_en` wins if both are asserted.
  - latch the word address = bits [18:2] of (`address` − `BASE_ADDR`) mod 2^32, plus `writeData`.
  - `cnt`←0; go to LOW.
- LOW: drive `SRAM_ADDR`={word,1'b0}.
  - Read: on the cycle `cnt`==ACCESS_CYCLES−1, capture `SRAM_DQ` into `readData[15:0]`.
  - Write: `SRAM_WE_N`=0 and `SRAM_DQ`=`writeData[15:0]` for the whole state.
  - Once `cnt`==ACCESS_CYCLES−1: `cnt`←0, go to HIGH.
- HIGH: same as LOW with `SRAM_ADDR`={word,1'b1}.
  - Read captures into `readData[31:16]`; write drives `writeData[31:16]`.
  - Once `cnt`==ACCESS_CYCLES−1: go to DONE.
- DONE: go to IDLE unconditionally. Requests still asserted in DONE are the completing instruction's and never restart an access.
- `ready`:
  - 1 in DONE, and 1 in IDLE with no request.
  - 0 in IDLE with a request, combinationally from `rd_en|wr_en`.
  - 0 throughout LOW and HIGH.
- `SRAM_DQ` is high-Z except in LOW/HIGH of a write. `SRAM_WE_N`=1 outside write LOW/HIGH.
- `SRAM_ADDR` holds its last value in IDLE/DONE.
- `readData` changes only at read capture cycles; writes never alter it.
- Requests are latched. Deasserting `rd_en`/`wr_en` or changing `address` mid-access has no effect until IDLE.
- Reset (reset=0, any state, async):
  - state←IDLE, `cnt`←0.
  - `readData`←0, `SRAM_ADDR`←0, `SRAM_WE_N`←1, `SRAM_DQ`←Z.
  - `ready` = ~(`rd_en|wr_en`).
  - Any access in flight is abandoned; a half-written word is not repaired.

## Timing
- A request first seen at IDLE cycle 0 keeps `ready` low for 1+2·ACCESS_CYCLES cycles. `ready` is high in the following (DONE) cycle; the pipeline advances on the edge ending DONE.
- ACCESS_CYCLES=2: `ready` low cycles 0–4, high cycle 5, IDLE at cycle 6.
- `readData` is valid (full word) from the cycle after the last HIGH cycle, i.e. during DONE. It is stable while `ready`=1.
- Back-to-back requests: the next access's IDLE-detect cycle immediately follows DONE. There is no extra bubble beyond that IDLE cycle.

## Test plan
- Reset with no requests -> `ready`=1, `readData`=0, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0.
- `wr_en`, `address`=1028, `writeData`=32'hDEADBEEF -> `ready` low 5 cycles.
  - SRAM model gets halfword 2=16'hBEEF and halfword 3=16'hDEAD.
  - `SRAM_WE_N` low exactly 4 cycles.
- Then `rd_en`, `address`=1028 -> `readData`=32'hDEADBEEF in DONE, `ready` high for exactly that one cycle, `SRAM_DQ` never driven by the controller.
- `rd_en`, then drop `rd_en` and change `address` to 2048 in LOW -> access to halfwords 2/3 still completes, and no second access follows.
- `rd_en` held continuously across DONE -> controller enters IDLE. A new access is started only when the pipeline presents the next request; there is no spurious repeat while in DONE.
- Write to `address`=1032, assert reset in HIGH -> immediate IDLE, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `readData`=0. The next request after release completes normally.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit word read/write from the MEM stage into two
// sequenced 16-bit accesses on an external SRAM. The low half goes first, then the high half.
// ready stays low while the transfer is in flight, so the pipeline freezes on ~ready.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 2,        // cycles each half-access is held on the pins
  parameter logic [31:0] BASE_ADDR     = 32'd1024  // CPU byte address of SRAM word 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned      CNT_W    = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,  // waiting for a request; ready follows ~(rd_en|wr_en)
    LOW,   // halfword {word,0} on the pins
    HIGH,  // halfword {word,1} on the pins
    DONE   // word complete; the pipeline advances on the edge that ends this state
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_write_q;
  logic [31:0]      wdata_q;
  logic             req;
  logic             last_cycle;
  logic             drive_en;
  logic [16:0]      word_addr;

  assign req        = rd_en | wr_en;
  assign last_cycle = (cnt_q == CNT_LAST);

  // The SRAM word index is taken from bits [18:2] of the address offset from
  // BASE_ADDR. The subtraction wraps modulo 2^32.
  assign word_addr = 17'((address - BASE_ADDR) >> 2);

  // Byte lanes, chip enable and output enable stay permanently asserted.
  // Only WE_N sequences the bus direction.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // The controller drives the data bus only during the two halves of a write.
  // At all other times the bus is released, so the SRAM can drive read data.
  assign drive_en  = is_write_q && ((state_q == LOW) || (state_q == HIGH));
  assign SRAM_WE_N = ~drive_en;
  assign SRAM_DQ   = drive_en ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking (=) here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the ready/freeze handshake.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = LOW;
      end
      LOW:  if (last_cycle) state_d = HIGH;
      HIGH: if (last_cycle) state_d = DONE;
      DONE: begin
        // Requests still high here belong to the instruction that is completing.
        // They must not start a new access.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the request, step the hold counter,
  // sequence SRAM_ADDR and capture the read halves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      readData   <= '0;
      SRAM_ADDR  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // A write wins when both enables are high.
            is_write_q <= wr_en;
            wdata_q    <= writeData;
            cnt_q      <= '0;
            SRAM_ADDR  <= {word_addr, 1'b0};
          end
        end
        LOW: begin
          if (last_cycle) begin
            cnt_q     <= '0;
            SRAM_ADDR <= {SRAM_ADDR[17:1], 1'b1};
            if (!is_write_q) readData[15:0] <= SRAM_DQ;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (last_cycle) begin
            cnt_q <= '0;
            if (!is_write_q) readData[31:16] <= SRAM_DQ;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;  // DONE: SRAM_ADDR and readData hold their values
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller.
// An SRAM model sits on the bus, and a word-level reference memory predicts read data
// from the address-mapping rule.
module tb_sram_controller;

  localparam int unsigned AC      = 2;
  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          LOW_CYC = 1 + 2 * AC;
  localparam logic [15:0] FILL    = 16'h5A3C;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [0:(1 << 18) - 1];
  logic [31:0] ref_mem  [int unsigned];

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the addressed halfword whenever WE_N is high,
  // and stores the bus value at each clock edge while WE_N is low.
  assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM word index of a CPU byte address: (addr - BASE) / 4, modulo 2^17.
  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % (1 << 17);
  endfunction

  // Present one request at a negedge. Each later cycle is sampled 1 ns after the negedge,
  // until ready rises (the DONE cycle).
  // The task counts ready-low cycles, write-strobe cycles, and idle-bus interference.
  // drop_at >= 0 withdraws the request and moves the address during that cycle.
  task automatic run_access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                            input bit hold, input int drop_at,
                            output int n_low, output int n_we, output int n_bus,
                            output logic [31:0] rd_done, output bit done);
    @(negedge clk);
    wr_en = is_wr; rd_en = !is_wr; address = a; writeData = d;
    n_low = 0; n_we = 0; n_bus = 0; done = 1'b0; rd_done = '0;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (!SRAM_WE_N) n_we++;
      else if (SRAM_DQ !== sram_mem[SRAM_ADDR]) n_bus++;
      if (ready) begin
        done    = 1'b1;
        rd_done = readData;
        if (!hold) begin rd_en = 1'b0; wr_en = 1'b0; end
      end else begin
        n_low++;
        if (c == drop_at) begin rd_en = 1'b0; wr_en = 1'b0; address = 32'd2048; end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int          n_low, n_we, n_bus;
    logic [31:0] rd, d, a, last_rd;
    bit          done;
    logic [31:0] wq[$];

    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = FILL;
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = 32'hFFFF_FFFF;

    // Reset state with no request pending.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",  32'(ready), 32'd1);
    check("rst_rdata",  readData, 32'd0);
    check("rst_we_n",   32'(SRAM_WE_N), 32'd1);
    check("rst_addr",   32'(SRAM_ADDR), 32'd0);
    check("rst_bus",    32'(SRAM_DQ), 32'(FILL));
    check("rst_tieoff", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
    rd_en = 1'b1; #1;
    check("rst_ready_req", 32'(ready), 32'd0);
    rd_en = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Directed write of DEADBEEF at byte address 1028 (halfwords 2 and 3).
    run_access(1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, -1, n_low, n_we, n_bus, rd, done);
    check("wr_done",  32'(done), 32'd1);
    check("wr_low",   32'(n_low), 32'(LOW_CYC));
    check("wr_we",    32'(n_we), 32'(2 * AC));
    check("wr_bus",   32'(n_bus), 32'd0);
    check("wr_hw2",   32'(sram_mem[2]), 32'h0000BEEF);
    check("wr_hw3",   32'(sram_mem[3]), 32'h0000DEAD);
    check("wr_rdata", rd, 32'd0);
    ref_mem[word_of(32'd1028)] = 32'hDEADBEEF;

    // Read the same word back.
    run_access(1'b0, 32'd1028, '0, 1'b0, -1, n_low, n_we, n_bus, rd, done);
    check("rd_done", 32'(done), 32'd1);
    check("rd_low",  32'(n_low), 32'(LOW_CYC));
    check("rd_data", rd, ref_mem[word_of(32'd1028)]);
    check("rd_we",   32'(n_we), 32'd0);
    check("rd_bus",  32'(n_bus), 32'd0);

    // The request is withdrawn and the address moved to 2048 during LOW.
    // The access must still finish on halfwords 2/3, and no second access may follow.
    run_access(1'b0, 32'd1028, '0, 1'b0, 1, n_low, n_we, n_bus, rd, done);
    check("drop_done", 32'(done), 32'd1);
    check("drop_low",  32'(n_low), 32'(LOW_CYC));
    check("drop_data", rd, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    #1;
    check("drop_idle_ready", 32'(ready), 32'd1);
    check("drop_idle_addr",  32'(SRAM_ADDR), 32'd3);
    check("drop_idle_rdata", readData, 32'hDEADBEEF);

    // rd_en is held through DONE. The following request must still see its own
    // IDLE-detect cycle, so the second run is again 1+2*AC cycles of ready low.
    run_access(1'b0, 32'd1028, '0, 1'b1, -1, n_low, n_we, n_bus, rd, done);
    check("hold1_done", 32'(done), 32'd1);
    check("hold1_low",  32'(n_low), 32'(LOW_CYC));
    run_access(1'b0, 32'd1028, '0, 1'b0, -1, n_low, n_we, n_bus, rd, done);
    check("hold2_done", 32'(done), 32'd1);
    check("hold2_low",  32'(n_low), 32'(LOW_CYC));
    check("hold2_data", rd, 32'hDEADBEEF);

    // Write to 1032, with reset asserted in the first HIGH cycle.
    d = $urandom;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1032; writeData = d;
    repeat (2 * AC - 1) @(negedge clk);
    #1;
    check("abort_pre_we", 32'(SRAM_WE_N), 32'd0);
    reset = 1'b0; #1;
    check("abort_we",    32'(SRAM_WE_N), 32'd1);
    check("abort_rdata", readData, 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_addr",  32'(SRAM_ADDR), 32'd0);
    check("abort_bus",   32'(SRAM_DQ), 32'(sram_mem[0]));
    wr_en = 1'b0; #1;
    check("abort_ready_idle", 32'(ready), 32'd1);
    @(negedge clk); reset = 1'b1;
    check("abort_hw4", 32'(sram_mem[4]), 32'(d[15:0]));
    check("abort_hw5", 32'(sram_mem[5]), 32'(FILL));
    ref_mem.delete(word_of(32'd1032));
    run_access(1'b0, 32'd1028, '0, 1'b0, -1, n_low, n_we, n_bus, rd, done);
    check("post_rst_low",  32'(n_low), 32'(LOW_CYC));
    check("post_rst_data", rd, 32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;

    // Randomized mix of writes and reads, checked against the word-level reference.
    for (int i = 0; i < 32; i++) begin
      if (wq.size() == 0 || $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = BASE + 32'($urandom_range(0, 511) * 4) + 32'($urandom_range(0, 3));
        d = $urandom;
        run_access(1'b1, a, d, 1'b0, -1, n_low, n_we, n_bus, rd, done);
        check("rnd_wr_low",   32'(n_low), 32'(LOW_CYC));
        check("rnd_wr_we",    32'(n_we), 32'(2 * AC));
        check("rnd_wr_lo",    32'(sram_mem[2 * word_of(a)]), 32'(d[15:0]));
        check("rnd_wr_hi",    32'(sram_mem[2 * word_of(a) + 1]), 32'(d[31:16]));
        check("rnd_wr_rdata", rd, last_rd);
        ref_mem[word_of(a)] = d;
        wq.push_back(a);
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        run_access(1'b0, a, '0, 1'b0, -1, n_low, n_we, n_bus, rd, done);
        check("rnd_rd_low",  32'(n_low), 32'(LOW_CYC));
        check("rnd_rd_we",   32'(n_we), 32'd0);
        check("rnd_rd_bus",  32'(n_bus), 32'd0);
        check("rnd_rd_data", rd, ref_mem[word_of(a)]);
        last_rd = ref_mem[word_of(a)];
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
